cookie_ctrl: RTL and testbench

COOKIE_CTRL -- requirements
Module: cookie_ctrl

---
 rtl/cookie_ctrl.sv | 149 ++++++++++++++
 tb/tb_cookie_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cookie_ctrl.sv
// -----------------------------------------------------------------------------
// cookie_ctrl
// Sequencer for a shift-loaded cellular-automaton grid ("cookie" array).
// A job optionally loads a fresh grid bit-serially, runs the grid for a
// programmed number of generations, snapshots it into the display chain and
// streams that chain back out bit-serially.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, do_load,   : job request (IDLE only), load-first select and
//   gens              : generation count, all sampled together with start
//   abort             : drop the current job, back to IDLE at the next edge
//   load_valid/ready, : host -> grid serial load handshake
//   load_bit
//   out_valid/ready,  : grid -> host serial readout handshake
//   out_bit
//   cookie_en, cookie_run, cookie_display, cookie_in_bit, cookie_disp_in :
//                       grid control strobes and serial data into the chains
//   cookie_disp_out   : tail of the grid display chain
//   busy, done        : job in progress, one-cycle completion pulse
// -----------------------------------------------------------------------------
module cookie_ctrl #(
  parameter int CELLS = 256,
  parameter int GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             do_load,
  input  logic [GEN_W-1:0] gens,
  input  logic             abort,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             load_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             cookie_en,
  output logic             cookie_run,
  output logic             cookie_display,
  output logic             cookie_in_bit,
  output logic             cookie_disp_in,
  input  logic             cookie_disp_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CELLS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, SNAP, DUMP} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [GEN_W-1:0] gen_cnt;

  // Strobes are decoded straight from state and the handshake inputs so a
  // transfer and its grid shift happen in the same cycle. Everything is held
  // low while rst is asserted so the grid sees no activity during reset.
  always_comb begin
    load_ready     = 1'b0;
    out_valid      = 1'b0;
    out_bit        = 1'b0;
    cookie_en      = 1'b0;
    cookie_run     = 1'b0;
    cookie_display = 1'b0;
    cookie_in_bit  = 1'b0;
    cookie_disp_in = 1'b0;
    done           = 1'b0;
    busy           = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      case (state)
        LOAD: begin
          load_ready    = 1'b1;
          cookie_en     = load_valid;
          cookie_in_bit = load_valid & load_bit;
        end
        RUN: begin
          // gen_cnt is never 0 here in normal flow; guard keeps the count exact
          if (gen_cnt != '0) begin
            cookie_en  = 1'b1;
            cookie_run = 1'b1;
          end
        end
        SNAP: cookie_display = 1'b1;
        DUMP: begin
          out_valid = 1'b1;
          out_bit   = cookie_disp_out;
          cookie_en = out_ready;
          // an aborted final transfer does not count as completion
          done      = out_ready && (bit_cnt == LAST_BIT) && !abort;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gen_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gen_cnt <= gens;
            if (do_load)         state <= LOAD;
            else if (gens == '0) state <= SNAP;
            else                 state <= RUN;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              // zero generations skips RUN entirely: no idle run-state cycle
              state   <= (gen_cnt == '0) ? SNAP : RUN;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (gen_cnt == '0) begin
            state <= SNAP;
          end else begin
            gen_cnt <= gen_cnt - 1'b1;
            if (gen_cnt == GEN_W'(1)) state <= SNAP;
          end
        end
        SNAP: state <= DUMP;
        DUMP: begin
          if (out_ready) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cookie_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cookie_ctrl
// Directed bench for cookie_ctrl with a behavioural stand-in for the grid:
// a load chain that inverts on every run cycle, copied into a display chain
// on the display strobe and shifted out on readout. Expected readout bits are
// queued when a job is started and compared as the DUT streams them out.
// -----------------------------------------------------------------------------
module tb_cookie_ctrl;

  localparam int N  = 256;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          do_load = 1'b0;
  logic [GW-1:0] gens = '0;
  logic          abort = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          load_bit = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_bit;
  logic          cookie_en, cookie_run, cookie_display;
  logic          cookie_in_bit, cookie_disp_in, cookie_disp_out;
  logic          busy, done;

  cookie_ctrl #(.CELLS(N), .GEN_W(GW)) dut (
    .clk(clk), .rst(rst), .start(start), .do_load(do_load), .gens(gens),
    .abort(abort), .load_valid(load_valid), .load_ready(load_ready),
    .load_bit(load_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .cookie_en(cookie_en), .cookie_run(cookie_run),
    .cookie_display(cookie_display), .cookie_in_bit(cookie_in_bit),
    .cookie_disp_in(cookie_disp_in), .cookie_disp_out(cookie_disp_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Grid stand-in
  logic [N-1:0] cells, disp;
  always @(posedge clk) begin
    if (cookie_en && cookie_run)            cells <= ~cells;
    else if (cookie_en && !out_valid)       cells <= {cells[N-2:0], cookie_in_bit};
    if (cookie_display)                     disp  <= cells;
    else if (cookie_en && out_valid && !cookie_run) disp <= {disp[N-2:0], cookie_disp_in};
  end
  assign cookie_disp_out = disp[N-1];

  logic [8:0] all_out;
  assign all_out = {busy, done, load_ready, out_valid, cookie_en, cookie_run,
                    cookie_display, cookie_in_bit, cookie_disp_in};

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference grid contents
  logic exp_q[$];
  logic ref_bits[N];
  logic inv = 1'b0;
  logic e_bit;

  // Per-job activity counters, cleared when a job is started
  int n_load, n_ready, n_run, n_disp, n_out, n_done, done_at, n_busy;

  task automatic check_b(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic check_i(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_load = 0; n_ready = 0; n_run = 0; n_disp = 0;
    n_out = 0; n_done = 0; done_at = -1; n_busy = 0;
  endtask

  // Monitor: strobe rules every cycle, scoreboard pop on each readout transfer
  always @(negedge clk) begin
    check_b("strobe_excl", (cookie_display && cookie_en) || (cookie_run && !cookie_en)
                           || (cookie_run && cookie_display), 1'b0);
    check_b("in_bit", cookie_in_bit, (load_ready && load_valid) ? load_bit : 1'b0);
    check_b("disp_in", cookie_disp_in, 1'b0);
    if (busy) n_busy++;
    if (load_ready) begin
      n_ready++;
      check_b("load_en", cookie_en, load_valid);
      if (load_valid) n_load++;
    end
    if (cookie_run) n_run++;
    if (cookie_display) n_disp++;
    if (out_valid) begin
      check_b("dump_en", cookie_en, out_ready);
      if (out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_i("sb_empty", 1, 0);
        end else begin
          e_bit = exp_q.pop_front();
          check_b("out_bit", out_bit, e_bit);
        end
      end
    end
    if (done) begin
      n_done++;
      done_at = n_out;
    end
  end

  // Queue expected readout for the job, then pulse start and scramble the
  // job parameters so the DUT must rely on what it latched.
  task automatic start_job(logic ld, int g);
    clr();
    if (ld) begin
      for (int i = 0; i < N; i++) ref_bits[i] = 1'($urandom_range(1));
      inv = 1'b0;
    end
    inv = inv ^ 1'(g & 1);
    for (int i = 0; i < N; i++) exp_q.push_back(ref_bits[i] ^ inv);
    start = 1'b1; do_load = ld; gens = GW'(g);
    tick();
    start = 1'b0; do_load = 1'($urandom_range(1)); gens = GW'($urandom_range(255));
  endtask

  task automatic drive_load(logic toggle, int nbits);
    int  idx = 0;
    logic ph = 1'b1;
    while (idx < nbits) begin
      load_valid = !toggle || ph;
      load_bit   = ref_bits[idx];
      tick();
      if (load_valid) idx++;
      ph = !ph;
    end
    load_valid = 1'b0;
    load_bit   = 1'b0;
  endtask

  task automatic wait_idle(int max, string tag);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check_b({tag, "_timeout"}, busy, 1'b0);
  endtask

  initial begin
    // Reset behaviour
    tick();
    check_i("rst_outs_during", int'(all_out), 0);
    tick();
    rst = 1'b0;
    tick();
    check_i("rst_outs_after", int'(all_out), 0);

    // Load + 3 generations, load_valid held high
    out_ready = 1'b1;
    start_job(1'b1, 3);
    check_b("a_busy", busy, 1'b1);
    drive_load(1'b0, N);
    wait_idle(600, "a");
    check_i("a_load", n_load, 256);
    check_i("a_ready", n_ready, 256);
    check_i("a_run", n_run, 3);
    check_i("a_disp", n_disp, 1);
    check_i("a_busy_cycles", n_busy, 516);
    check_i("a_out", n_out, 256);
    check_i("a_done_at", done_at, 256);
    check_i("a_done_cnt", n_done, 1);
    check_i("a_sb_left", exp_q.size(), 0);

    // Evolve-only, zero generations
    start_job(1'b0, 0);
    check_b("b_snap_next", cookie_display, 1'b1);
    check_b("b_no_run", cookie_run, 1'b0);
    wait_idle(400, "b");
    check_i("b_run", n_run, 0);
    check_i("b_busy_cycles", n_busy, 257);
    check_i("b_done_at", done_at, 256);
    check_i("b_done_cnt", n_done, 1);
    check_i("b_sb_left", exp_q.size(), 0);

    // Toggled load_valid, then a 10-cycle readout stall
    start_job(1'b1, 1);
    drive_load(1'b1, N);
    begin
      int n = 0;
      while (n_out < 50 && n < 1000) begin
        tick();
        n++;
      end
    end
    out_ready = 1'b0;
    check_i("c_reach50", n_out, 50);
    begin
      logic hold;
      hold = out_bit;
      for (int i = 0; i < 10; i++) begin
        tick();
        check_b("c_stall_bit", out_bit, hold);
        check_b("c_stall_en", cookie_en, 1'b0);
      end
    end
    check_i("c_stall_cnt", n_out, 50);
    out_ready = 1'b1;
    wait_idle(400, "c");
    check_i("c_ready", n_ready, 511);
    check_i("c_load", n_load, 256);
    check_i("c_run", n_run, 1);
    check_i("c_out", n_out, 256);
    check_i("c_done_cnt", n_done, 1);
    check_i("c_sb_left", exp_q.size(), 0);

    // Abort at load bit 100, then a fresh full job
    start_job(1'b1, 2);
    drive_load(1'b0, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_b("d_abort_idle", busy, 1'b0);
    check_i("d_abort_load", n_load, 100);
    check_i("d_abort_done", n_done, 0);
    exp_q.delete();
    start_job(1'b1, 2);
    drive_load(1'b0, N);
    wait_idle(600, "d");
    check_i("d_ready", n_ready, 256);
    check_i("d_run", n_run, 2);
    check_i("d_out", n_out, 256);
    check_i("d_done_cnt", n_done, 1);
    check_i("d_sb_left", exp_q.size(), 0);

    // Reset in the middle of RUN
    start_job(1'b0, 50);
    repeat (5) tick();
    check_b("e_running", cookie_run, 1'b1);
    rst = 1'b1;
    tick();
    check_i("e_outs_in_rst", int'(all_out), 0);
    rst = 1'b0;
    tick();
    check_i("e_outs_after", int'(all_out), 0);
    check_i("e_done", n_done, 0);
    exp_q.delete();

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; do_load = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_b("e_start_abort", busy, 1'b0);

    // Reload with zero generations
    start_job(1'b1, 0);
    drive_load(1'b0, N);
    wait_idle(600, "f");
    check_i("f_run", n_run, 0);
    check_i("f_disp", n_disp, 1);
    check_i("f_done_cnt", n_done, 1);
    check_i("f_sb_left", exp_q.size(), 0);

    // start pulsed during RUN, gens changed after start
    start_job(1'b0, 5);
    tick();
    start = 1'b1; gens = 8'd200; do_load = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(600, "g");
    check_i("g_run", n_run, 5);
    check_i("g_load", n_load, 0);
    check_i("g_out", n_out, 256);
    check_i("g_done_cnt", n_done, 1);
    check_i("g_sb_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
